// File: rtl/riscv_pkg.sv
// Shared types for the reduced RISC-V multi-cycle core: FSM states, instruction
// classes, opcode/funct encodings and the ALU / PC / write-back / trap encodings.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BEQ,
        CL_JAL
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } aluctrl_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'd0,
        TC_ILLEGAL = 2'd1,
        TC_IMEM    = 2'd2,
        TC_DMEM    = 2'd3
    } trap_cause_t;

    // I-type has no subtract: its bit 30 belongs to the immediate, so callers pass sub=0.
    function automatic aluctrl_t funct_op(input logic [2:0] f3, input logic sub);
        case (f3)
            F3_AND:  return ALU_AND;
            F3_OR:   return ALU_OR;
            default: return sub ? ALU_SUB : ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Instruction classifier: opcode/funct -> class, ALU op, operand-2 select, legal.
// Latency: purely combinational, no state.
// Backpressure: none; sampled by the controller only in DECODE.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output iclass_t    iclass,
    output aluctrl_t   aluctrl,
    output logic       alusrc,
    output logic       legal
);

    logic alu_f3_ok;

    assign alu_f3_ok = (funct3 == F3_ADD) || (funct3 == F3_AND) || (funct3 == F3_OR);

    always_comb begin
        iclass  = CL_R;
        aluctrl = ALU_ADD;
        alusrc  = 1'b0;
        legal   = 1'b0;
        case (opcode)
            OP_R: begin
                iclass  = CL_R;
                aluctrl = funct_op(funct3, funct7_5);
                legal   = alu_f3_ok;
            end
            OP_I: begin
                iclass  = CL_I;
                aluctrl = funct_op(funct3, 1'b0);
                alusrc  = 1'b1;
                legal   = alu_f3_ok;
            end
            OP_LOAD: begin
                iclass = CL_LOAD;
                alusrc = 1'b1;
                legal  = (funct3 == F3_WORD);
            end
            OP_STORE: begin
                iclass = CL_STORE;
                alusrc = 1'b1;
                legal  = (funct3 == F3_WORD);
            end
            OP_BRANCH: begin
                iclass  = CL_BEQ;
                aluctrl = ALU_SUB;
                legal   = (funct3 == F3_BEQ);
            end
            OP_JAL: begin
                iclass = CL_JAL;
                legal  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with trap, wait and retire counters.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: imem/dmem requests held until ready; MEM_TIMEOUT waits without ready traps.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 eq,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 alusrc,
    output logic [2:0]           aluctrl,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    iclass_t     cls_q;
    aluctrl_t    aluop_q;
    logic        alusrc_q;
    trap_cause_t cause_q, cause_d;
    logic [WW-1:0] wait_q, wait_d;

    iclass_t  dec_class;
    aluctrl_t dec_aluctrl;
    logic     dec_alusrc;
    logic     dec_legal;

    alu_decoder u_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .iclass   (dec_class),
        .aluctrl  (dec_aluctrl),
        .alusrc   (dec_alusrc),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Class and ALU controls are latched in DECODE so later outputs never see opcode/funct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q    <= CL_R;
            aluop_q  <= ALU_ADD;
            alusrc_q <= 1'b0;
            cause_q  <= TC_NONE;
            wait_q   <= '0;
            retired  <= '0;
        end else begin
            if (state_q == ST_DECODE) begin
                cls_q    <= dec_class;
                aluop_q  <= dec_aluctrl;
                alusrc_q <= dec_alusrc;
            end
            cause_q <= cause_d;
            wait_q  <= wait_d;
            if (pc_we) begin
                retired <= retired + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs are forced low while rst_n is low so nothing is written during reset.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        wait_d     = '0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        alusrc     = 1'b0;
        aluctrl    = ALU_ADD;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        halted     = 1'b0;
        trap_cause = TC_NONE;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = ST_TRAP;
                        cause_d = TC_IMEM;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                ST_DECODE: begin
                    if (dec_legal) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_TRAP;
                        cause_d = TC_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    aluctrl = aluop_q;
                    alusrc  = alusrc_q;
                    case (cls_q)
                        CL_LOAD, CL_STORE: state_d = ST_MEM;
                        CL_BEQ: begin
                            pc_we   = 1'b1;
                            pc_src  = eq ? PC_IMM : PC_PLUS4;
                            state_d = ST_FETCH;
                        end
                        CL_JAL: begin
                            reg_we  = 1'b1;
                            wb_sel  = WB_PC4;
                            pc_we   = 1'b1;
                            pc_src  = PC_IMM;
                            state_d = ST_FETCH;
                        end
                        default: state_d = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls_q == CL_STORE);
                    aluctrl  = ALU_ADD;
                    alusrc   = 1'b1;
                    if (dmem_ready) begin
                        if (cls_q == CL_STORE) begin
                            pc_we   = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = ST_TRAP;
                        cause_d = TC_DMEM;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                ST_WB: begin
                    reg_we  = 1'b1;
                    wb_sel  = (cls_q == CL_LOAD) ? WB_MEM : WB_ALU;
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_TRAP: begin
                    halted     = 1'b1;
                    trap_cause = cause_q;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

endmodule
